// File: rtl/zigbee_arb_pkg.sv
// ---------------------------------------------------------------------------
// zigbee_arb_pkg : shared types and defaults for chip_path_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package zigbee_arb_pkg;

  localparam int MAX_LEN_DEFAULT      = 32;
  localparam int GUARD_CYCLES_DEFAULT = 1;
  localparam int GUARD_W              = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  // On a tie the requester that did not win last time is served.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_winner);
    return (req == 2'b11) ? ~last_winner : req[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/chip_path_arbiter_mux211.sv
// ---------------------------------------------------------------------------
// MUX211 : 2:1 single-bit chip multiplexer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module MUX211 (
  input  logic [1:0] inData,
  input  logic       inSel,
  output logic       outData
);

  assign outData = inData[inSel];

endmodule

`default_nettype wire

// File: rtl/chip_path_arbiter.sv
// ---------------------------------------------------------------------------
// chip_path_arbiter : two-requester round-robin chip-path arbiter with burst
// length limit and guard gap between grants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chip_path_arbiter
  import zigbee_arb_pkg::*;
#(
  parameter int MAX_LEN      = MAX_LEN_DEFAULT,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
  input  logic       inClk,
  input  logic       inResetn,
  input  logic [1:0] inReq,
  input  logic [1:0] inValid,
  input  logic [1:0] inData,
  input  logic [1:0] inLast,
  output logic [1:0] outGnt,
  output logic       outSel,
  output logic       outData,
  output logic       outValid,
  output logic       outTimeout
);

  localparam int                CNT_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0]  BEAT_FINAL = CNT_W'(MAX_LEN - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

  arb_state_e         state_q;
  logic [1:0]         gnt_q;
  logic [1:0]         gnt_d;
  logic               sel_q;
  logic               sel_d;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GUARD_W-1:0] guard_q;

  logic in_grant;
  logic sel_valid;
  logic sel_last;
  logic sel_req;
  logic rel_normal;
  logic rel_timeout;
  logic rel_abort;
  logic rel_any;

  assign in_grant  = (state_q == ST_GRANT);
  assign sel_valid = inValid[sel_q];
  assign sel_last  = inLast[sel_q];
  assign sel_req   = inReq[sel_q];

  // Release causes in priority order; a last marker on the final allowed
  // beat counts as a normal release, so the timeout term excludes it.
  assign rel_normal  = in_grant & sel_valid & sel_last;
  assign rel_timeout = in_grant & sel_valid & ~sel_last & (cnt_q == BEAT_FINAL);
  assign rel_abort   = in_grant & ~sel_req;
  assign rel_any     = rel_normal | rel_timeout | rel_abort;

  assign sel_d = rr_pick(inReq, last_q);
  assign gnt_d = sel_d ? 2'b10 : 2'b01;

  always_ff @(posedge inClk or negedge inResetn) begin
    if (!inResetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      guard_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inReq != 2'b00) begin
            state_q <= ST_GRANT;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (rel_any) begin
            state_q <= ST_GUARD;
            gnt_q   <= 2'b00;
            last_q  <= sel_q;
            guard_q <= GUARD_LOAD;
          end else if (sel_valid) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GUARD: begin
          if (guard_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            guard_q <= guard_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  MUX211 u_mux211 (
    .inData  (inData),
    .inSel   (outSel),
    .outData (outData)
  );

  assign outGnt     = gnt_q;
  assign outSel     = sel_q;
  assign outValid   = in_grant & sel_valid;
  assign outTimeout = rel_timeout;

endmodule

`default_nettype wire

// File: tb/tb_chip_path_arbiter.sv
// ---------------------------------------------------------------------------
// tb_chip_path_arbiter : randomized scoreboard bench for chip_path_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chip_path_arbiter;

  localparam int MAX_LEN      = 32;
  localparam int GUARD_CYCLES = 1;

  logic       inClk = 1'b0;
  logic       inResetn;
  logic [1:0] inReq, inValid, inData, inLast;
  logic [1:0] outGnt;
  logic       outSel, outData, outValid, outTimeout;

  chip_path_arbiter #(.MAX_LEN(MAX_LEN), .GUARD_CYCLES(GUARD_CYCLES)) dut (
    .inClk      (inClk),
    .inResetn   (inResetn),
    .inReq      (inReq),
    .inValid    (inValid),
    .inData     (inData),
    .inLast     (inLast),
    .outGnt     (outGnt),
    .outSel     (outSel),
    .outData    (outData),
    .outValid   (outValid),
    .outTimeout (outTimeout)
  );

  initial forever #5 inClk = ~inClk;

  typedef struct { int cyc; logic [1:0] gnt; logic sel; } gnt_ev_t;
  typedef struct { int cyc; logic data; logic sel; logic tmo; } beat_t;

  gnt_ev_t gnt_sb[$];
  beat_t   beat_sb[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit force11 = 1'b0;

  // Reference model: who owns the path, beats delivered so far, guard
  // cycles still to wait, and the most recently served requester.
  int         m_owner;
  int         m_cool;
  int         m_beats;
  logic       m_sel;
  logic       m_last;
  logic [1:0] m_prev_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_cool     = 0;
    m_beats    = 0;
    m_sel      = 1'b0;
    m_last     = 1'b1;
    m_prev_gnt = 2'b00;
  endtask

  task automatic model_step();
    logic s;
    if (m_owner >= 0) begin
      s = m_owner[0];
      if ((inValid[s] && inLast[s]) || (inValid[s] && m_beats == MAX_LEN - 1) || !inReq[s]) begin
        m_last  = s;
        m_owner = -1;
        m_cool  = GUARD_CYCLES;
      end else if (inValid[s]) begin
        m_beats++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (inReq != 2'b00) begin
      if (inReq == 2'b11) m_owner = m_last ? 0 : 1;
      else                m_owner = inReq[1] ? 1 : 0;
      m_sel   = m_owner[0];
      m_beats = 0;
    end
  endtask

  task automatic drive_and_push(input int p_req, input int p_hold, input int p_valid,
                                input int p_last, input bit last_at_max);
    logic [1:0] r, v, l, g;
    logic       s;
    beat_t      b;
    gnt_ev_t    e;
    s = m_owner[0];
    for (int i = 0; i < 2; i++) begin
      r[i] = ($urandom_range(99) < ((m_owner == i) ? p_hold : p_req));
      v[i] = ($urandom_range(99) < p_valid);
      l[i] = ($urandom_range(99) < p_last);
    end
    if (force11) r = 2'b11;
    if (last_at_max && m_owner >= 0 && m_beats == MAX_LEN - 1) begin
      v[s] = 1'b1;
      l[s] = 1'b1;
    end
    inReq   = r;
    inValid = v;
    inLast  = l;
    inData  = 2'($urandom_range(3));
    g = (m_owner < 0) ? 2'b00 : (s ? 2'b10 : 2'b01);
    if (g != m_prev_gnt) begin
      e.cyc = cyc; e.gnt = g; e.sel = m_sel;
      gnt_sb.push_back(e);
    end
    m_prev_gnt = g;
    if (m_owner >= 0 && v[s]) begin
      b.cyc  = cyc;
      b.data = inData[m_sel];
      b.sel  = m_sel;
      b.tmo  = !l[s] && (m_beats == MAX_LEN - 1);
      beat_sb.push_back(b);
    end
  endtask

  task automatic reset_pulse();
    #2;
    inResetn = 1'b0;
    mon_en   = 1'b0;
    #1;
    chk("midrst_gnt", {30'd0, outGnt}, 32'd0);
    chk("midrst_sel", {31'd0, outSel}, 32'd0);
    chk("midrst_valid", {31'd0, outValid}, 32'd0);
    chk("midrst_timeout", {31'd0, outTimeout}, 32'd0);
    beat_sb.delete();
    gnt_sb.delete();
    @(posedge inClk); #1;
    cyc++;
    inResetn = 1'b1;
    model_reset();
    mon_en  = 1'b1;
    force11 = 1'b1;
  endtask

  task automatic run_phase(input int n, input int p_req, input int p_hold, input int p_valid,
                           input int p_last, input bit last_at_max, input int rst_at);
    bit rst_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_and_push(p_req, p_hold, p_valid, p_last, last_at_max);
      force11 = 1'b0;
      if (rst_at >= 0 && !rst_done && i >= rst_at &&
          ((m_owner == 1 && m_beats >= 2) || i >= rst_at + 60)) begin
        reset_pulse();
        rst_done = 1'b1;
      end else begin
        @(posedge inClk); #1;
        cyc++;
        model_step();
      end
    end
  endtask

  // Monitor: compares whenever the DUT changes its grant or presents a beat.
  initial begin
    logic [1:0] prev;
    gnt_ev_t    e;
    beat_t      b;
    prev = 2'b00;
    forever begin
      @(negedge inClk);
      if (!mon_en) begin
        prev = outGnt;
      end else begin
        while (gnt_sb.size() > 0 && gnt_sb[0].cyc < cyc) begin
          e = gnt_sb.pop_front();
          chk("gnt_missing", {30'd0, outGnt}, {30'd0, e.gnt});
        end
        while (beat_sb.size() > 0 && beat_sb[0].cyc < cyc) begin
          b = beat_sb.pop_front();
          chk("beat_missing", {31'd0, outValid}, 32'd1);
        end
        if (outGnt != prev) begin
          if (gnt_sb.size() == 0) begin
            chk("gnt_unexpected", {30'd0, outGnt}, {30'd0, prev});
          end else begin
            e = gnt_sb.pop_front();
            chk("gnt_value", {30'd0, outGnt}, {30'd0, e.gnt});
            chk("gnt_sel", {31'd0, outSel}, {31'd0, e.sel});
            chk("gnt_cycle", cyc, e.cyc);
          end
        end
        prev = outGnt;
        if (outValid) begin
          if (beat_sb.size() == 0) begin
            chk("beat_unexpected", {31'd0, outValid}, 32'd0);
          end else begin
            b = beat_sb.pop_front();
            chk("beat_data_sel_tmo", {29'd0, outData, outSel, outTimeout}, {29'd0, b.data, b.sel, b.tmo});
            chk("beat_cycle", cyc, b.cyc);
          end
        end else if (outTimeout) begin
          chk("timeout_without_valid", {31'd0, outTimeout}, 32'd0);
        end
      end
    end
  end

  initial begin
    inResetn = 1'b0;
    inReq    = 2'b11;
    inValid  = 2'b11;
    inData   = 2'b11;
    inLast   = 2'b00;
    model_reset();
    repeat (2) @(posedge inClk);
    #1;
    chk("rst_gnt", {30'd0, outGnt}, 32'd0);
    chk("rst_sel", {31'd0, outSel}, 32'd0);
    chk("rst_valid", {31'd0, outValid}, 32'd0);
    chk("rst_timeout", {31'd0, outTimeout}, 32'd0);
    inResetn = 1'b1;
    mon_en   = 1'b1;
    force11  = 1'b1;

    // mixed traffic, frequent short bursts and aborts
    run_phase(300, 60, 97, 70, 15, 1'b0, 120);
    // saturated requests, bursts run into the beat limit
    run_phase(500, 100, 100, 90, 1, 1'b0, 200);
    // last marker lands exactly on the final allowed beat
    run_phase(250, 100, 100, 100, 0, 1'b1, -1);
    // sparse traffic with frequent request drops
    run_phase(300, 30, 90, 50, 20, 1'b0, 100);

    drive_and_push(50, 95, 70, 10, 1'b0);
    @(negedge inClk);
    #1;
    mon_en = 1'b0;
    chk("beat_sb_drained", beat_sb.size(), 32'd0);
    chk("gnt_sb_drained", gnt_sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chip_path_arbiter.md
CHIP_PATH_ARBITER -- requirements
Module: chip_path_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 32, SHALL set the maximum valid beats per grant (range 2..255).
REQ-002 Parameter GUARD_CYCLES, default 1, SHALL set the idle cycles between grants (range 1..15).
REQ-003 inClk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 inResetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 inReq  input  2  SHALL carry the per-requester access request; bit i belongs to requester i.
REQ-006 inValid  input  2  SHALL carry the per-requester chip-valid strobe.
REQ-007 inData  input  2  SHALL carry the per-requester chip bit.
REQ-008 inLast  input  2  SHALL mark the final chip of a burst; it is meaningful only with the matching inValid.
REQ-009 outGnt  output  2  SHALL be the grant, one-hot or zero.
REQ-010 outSel  output  1  SHALL be the index of the granted requester and SHALL drive the 2:1 chip mux select.
REQ-011 outData  output  1  SHALL be the muxed chip bit, inData[outSel].
REQ-012 outValid  output  1  SHALL equal inValid[outSel] in GRANT and SHALL be 0 otherwise.
REQ-013 outTimeout  output  1  SHALL be a one-cycle pulse on a forced release at MAX_LEN.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT, GUARD.
REQ-015 In IDLE with exactly one inReq bit set, the FSM SHALL enter GRANT for that requester; outGnt SHALL assert on the next cycle (1-cycle latency).
REQ-016 In IDLE with both inReq bits set, the grant SHALL go to the requester not recorded in the last-winner pointer (round-robin).
REQ-017 In IDLE with inReq=00, the FSM SHALL stay in IDLE.
REQ-018 On entry to GRANT, the beat counter SHALL clear; it SHALL increment on each cycle where inValid[outSel]=1.
REQ-019 GRANT SHALL release to GUARD on the first of these conditions, evaluated in priority order:
  - inValid[outSel] & inLast[outSel]: normal release, no timeout;
  - inValid[outSel] with beat count = MAX_LEN-1: forced release, outTimeout=1 in the same cycle;
  - inReq[outSel]=0: abort release, no timeout.
REQ-020 If inLast coincides with the MAX_LEN beat, the release SHALL be normal and outTimeout SHALL stay 0.
REQ-021 On any release, the last-winner pointer SHALL load the served index, and outGnt SHALL be 00 from the next cycle.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles with outGnt=00 and outValid=0, then go to IDLE; inReq SHALL be ignored during GUARD.
REQ-023 outSel SHALL hold its last value in IDLE and GUARD.
REQ-024 The non-granted requester's inValid, inData and inLast SHALL have no effect.
REQ-025 outData SHALL be combinational from inData through the mux with no added register; outValid SHALL also be combinational, gated by state.
REQ-026 The counter width SHALL be ceil(log2(MAX_LEN)); it SHALL never wrap within a grant.

Reset
REQ-027 While inResetn=0: state=IDLE, outGnt=00, outSel=0, outValid=0, outTimeout=0, counter=0, last-winner=1 (requester 0 wins the first tie).
REQ-028 Reset asserted mid-GRANT or mid-GUARD SHALL abort immediately, with no timeout pulse; after release, arbitration SHALL restart from IDLE.

Structure
REQ-029 Package zigbee_arb_pkg SHALL hold the state enum typedef and the MAX_LEN and GUARD_CYCLES default constants.
REQ-030 The chip path SHALL instantiate MUX211 once, with inData to inData, outSel to inSel, and outData to outData; no other sub-module.

Verification
REQ-031 inReq=01 at cycle N -> outGnt=01 and outSel=0 at N+1; a 5-beat burst with inLast on beat 5 at cycle M -> outGnt=00 at M+1, IDLE at M+2 (GUARD_CYCLES=1).
REQ-032 inReq=11 persistently after reset -> grants alternate 01, 10, 01, ...; each grant starts 2 cycles after the previous release.
REQ-033 inReq=10, inValid[1] held high, no inLast, MAX_LEN=32 -> outTimeout pulses on the 32nd valid beat; outGnt=00 the next cycle.
REQ-034 inLast on the 32nd beat -> release with outTimeout=0.
REQ-035 Granted requester drops inReq mid-burst -> release without timeout; toggling the other requester's inValid/inData during the grant -> outData and outValid unaffected.
REQ-036 inResetn low for 1 cycle mid-GRANT -> all outputs 0 immediately; with inReq=11 afterwards -> requester 0 is granted first.
